// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer: loads a word-count-prefixed byte stream into instruction memory,
// then gates core commit for continuous run, single-step and halt.
module boot_run_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_req_i,
    input  logic              run_req_i,
    input  logic              step_req_i,
    input  logic              halt_req_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic [31:0]       instr_i,
    output logic              cpu_en_o,
    output logic              cpu_rst_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [2:0]        state_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam int          CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_HDR  = 3'd1,
        LOAD_DATA = 3'd2,
        RUN       = 3'd3,
        STEP      = 3'd4,
        HALT      = 3'd5,
        ERR       = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       count_q, count_d;
    logic [23:0]       buf_q, buf_d;
    logic [CNT_W-1:0]  idle_q, idle_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              is_ecall;
    logic [15:0]       hdr_n;
    logic              last_word;

    assign is_ecall  = (instr_i == ECALL);
    assign hdr_n     = {rx_data_i, count_q[7:0]};
    // Compare in 32 bits so a full-depth image (N = 2^ADDR_W) terminates correctly.
    assign last_word = ((32'(addr_q) + 32'd1) == 32'(count_q));

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        count_d    = count_q;
        buf_d      = buf_q;
        idle_d     = idle_q;
        addr_d     = we_q ? addr_q + ADDR_W'(1) : addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (load_req_i)      state_d = LOAD_HDR;
                else if (step_req_i) state_d = STEP;
                else if (run_req_i)  state_d = RUN;
            end
            LOAD_HDR, LOAD_DATA: begin
                if (load_req_i) begin
                    state_d = LOAD_HDR;
                end else if (rx_valid_i) begin
                    idle_d = '0;
                    if (state_q == LOAD_HDR) begin
                        if (byte_idx_q == 2'd0) begin
                            count_d[7:0] = rx_data_i;
                            byte_idx_d   = 2'd1;
                        end else begin
                            count_d    = hdr_n;
                            byte_idx_d = 2'd0;
                            if (hdr_n == 16'd0) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else if (32'(hdr_n) > (32'd1 << ADDR_W)) begin
                                state_d = ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d = LOAD_DATA;
                                addr_d  = '0;
                            end
                        end
                    end else if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {rx_data_i, buf_q};
                        byte_idx_d = 2'd0;
                        if (last_word) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        buf_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if (idle_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            ERR: begin
                if (load_req_i) state_d = LOAD_HDR;
            end
            RUN: begin
                if (halt_req_i || is_ecall) state_d = HALT;
            end
            STEP: begin
                state_d = HALT;
            end
            HALT: begin
                if (load_req_i)      state_d = LOAD_HDR;
                else if (step_req_i) state_d = STEP;
                else if (run_req_i)  state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        // Any accepted load request restarts the header from a clean slate.
        if (state_d == LOAD_HDR && state_q != LOAD_HDR || (state_q == LOAD_HDR && load_req_i)) begin
            byte_idx_d = 2'd0;
            count_d    = '0;
            idle_d     = '0;
            addr_d     = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            count_q    <= '0;
            buf_q      <= '0;
            idle_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
            idle_q     <= idle_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cpu_rst_o    = (state_q == IDLE) || (state_q == LOAD_HDR) ||
                          (state_q == LOAD_DATA) || (state_q == ERR);
    // An ecall is never committed, so the PC stays parked on it.
    assign cpu_en_o     = ((state_q == RUN) || (state_q == STEP)) && !is_ecall;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign state_o      = state_q;
    assign load_done_o  = done_q;
    assign load_err_o   = err_q;

endmodule

// File: doc/boot_run_ctrl.md
# boot_run_ctrl

Execution sequencer for the single-cycle RISC-V core. It loads a program image from a UART byte stream into instruction memory and holds the core in reset while it does so. It then gates instruction commit for continuous run, single-step or halt, so every PC, register-file and memory update is enabled only by this block. It sits between the board UART receiver and buttons on one side, and the core's fetch and commit enables plus the instruction-memory write port on the other.

## Interface
- ADDR_W, 14: instruction-memory word-address width; depth = 2^ADDR_W words.
- TIMEOUT, 1000000: cycles without a received byte, while loading, before the load aborts.
- clk  in  1  system clock (the CPU clock domain).
- reset  in  1  synchronous, active-high reset.
- load_req / run_req / step_req / halt_req  in  1 each  single-cycle request pulses from debounced buttons.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- rx_data  in  8  received UART byte.
- instr  in  32  instruction currently fetched by the core.
- cpu_en  out  1  core commits the current instruction at this clock edge.
- cpu_rst  out  1  holds core PC at 0 and register file cleared.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for imem_we.
- imem_wdata  out  32  word for imem_we.
- state  out  3  current state encoding, for LEDs.
- load_done  out  1  one-cycle pulse on successful load completion.
- load_err  out  1  sticky load-abort flag.

## Operation
- States and encodings: IDLE=0, LOAD_HDR=1, LOAD_DATA=2, RUN=3, STEP=4, HALT=5, ERR=6.
- Request priority when several arrive in the same cycle: load_req > halt_req > step_req > run_req. Requests that are not legal in the current state are ignored.
- IDLE: load_req → LOAD_HDR; run_req → RUN; step_req → STEP.
- LOAD_HDR: receives two bytes, low byte first, forming a 16-bit word count N.
  - N=0 → IDLE, with load_done pulsed.
  - N>2^ADDR_W → ERR.
  - Otherwise → LOAD_DATA with word address 0 and byte index 0.
- LOAD_DATA: each byte is placed little-endian at byte index 0..3.
  - The 4th byte completes the word, which is written to imem_addr; the address then increments.
  - After word N is written → IDLE.
- Timeout: in LOAD_HDR and LOAD_DATA an idle counter clears on every rx_valid. When it reaches TIMEOUT → ERR and load_err is set.
- ERR: only load_req leaves ERR (→ LOAD_HDR, which also clears load_err).
- RUN: cpu_en=1 every cycle except when instr==32'h00000073 (ecall). An ecall or halt_req → HALT. The ecall itself is not committed, so the PC stays on it.
- STEP: cpu_en=1 for exactly one cycle (0 if instr is ecall), then → HALT.
- HALT: cpu_en=0. run_req → RUN; step_req → STEP; load_req → LOAD_HDR.
  - run_req or step_req while parked on an ecall produces no commit and returns to HALT.
- cpu_rst is combinational from state: 1 in IDLE, LOAD_HDR, LOAD_DATA and ERR; 0 in RUN, STEP and HALT.
- cpu_en is combinational from state and instr.
- rx_valid outside the LOAD states is ignored.

## Timing
- Reset values: state=IDLE, cpu_en=0, cpu_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0. The idle counter, byte index and word count are cleared.
- A request pulse sampled at edge k makes the new state visible at cycle k+1. In the first RUN or STEP cycle, cpu_rst=0 and cpu_en=1.
- imem_we is registered. It is high for exactly one cycle, the cycle after the 4th rx_valid of a word. imem_addr and imem_wdata are stable during that cycle, and imem_addr increments on the following edge.
- rx_valid on every consecutive cycle is supported with no byte loss; back-to-back words produce imem_we pulses spaced 4 cycles apart.
- For the final word, state=IDLE and load_done=1 in the same cycle as its imem_we pulse.
- ERR is entered on the edge where the idle count equals TIMEOUT, i.e. TIMEOUT cycles after the last byte.
- Reset mid-load returns to IDLE next cycle. Any partial word is discarded and no imem_we is issued. Already-written words remain in memory.
- load_req while in LOAD restarts the header (LOAD_HDR, address 0).
- halt_req coincident with ecall → HALT; there is no difference in outcome.

## Test plan
- Load N=2: bytes 02 00 78 56 34 12 EF BE AD DE, one per cycle → imem_we at addr 0 with 12345678, then at addr 1 with DEADBEEF; load_done pulses with the second write; state=0.
- Header 00 00 → IDLE with load_done, no imem_we. Header 01 40 with ADDR_W=14 (N=0x4001 > 2^14) → ERR, load_err=1.
- Timeout (TIMEOUT=16): header plus 2 data bytes, then silence → ERR exactly 16 cycles after the last byte, no imem_we. A following load_req clears load_err.
- run_req with instr≠ecall → cpu_en=1 each cycle. When instr=00000073 arrives, cpu_en=0 the same cycle and state=HALT the next cycle.
- From HALT, step_req → exactly one cycle with cpu_en=1, then HALT. Same-cycle step_req and run_req → STEP (priority).
- Reset asserted after 5 bytes of a load → IDLE, cpu_rst=1, no imem_we issued for the partial word.
